// File: rtl/ms_countdown_timer_pkg.sv
// ----------------------------------------------------------------------------
// ms_countdown_timer_pkg
// Shared definitions for the millisecond countdown timer and its prescaler.
//   state_t       : FSM state encoding (IDLE=00, RUN=01, PAUSED=10, DONE=11)
//   TICKS_PER_MS  : clk cycles per 1 ms tick at 50 MHz (used by the prescaler)
//   DEFAULT_WIDTH : default width of the interval / remaining counter
// ----------------------------------------------------------------------------
package ms_countdown_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10,
    DONE   = 2'b11
  } state_t;

  localparam int TICKS_PER_MS  = 50000;
  localparam int DEFAULT_WIDTH = 16;

endpackage

// File: rtl/ms_countdown_timer.sv
// ----------------------------------------------------------------------------
// ms_countdown_timer
// Loads an interval in ms, counts it down on each 1 ms tick from the
// prescaler, and flags expiry. The prescaler sits beside this block in the
// parent: tick_en drives its enable and its pulse comes back on tick_in.
//
// Ports:
//   clk        in   system clock (50 MHz)
//   rst        in   synchronous reset, active-low
//   start      in   1-cycle request: load load_value and begin counting
//   load_value in   interval in ms, sampled only on the start cycle
//   pause      in   level; suspends counting while high
//   cancel     in   1-cycle abort back to IDLE
//   tick_in    in   1 ms pulse from the prescaler
//   tick_en    out  prescaler enable; high only in RUN
//   remaining  out  ms left in the current interval
//   busy       out  high in RUN or PAUSED
//   done       out  1-cycle pulse on expiry
//   expired    out  high in DONE until the next start or cancel
// ----------------------------------------------------------------------------
module ms_countdown_timer
  import ms_countdown_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_value,
  input  logic             pause,
  input  logic             cancel,
  input  logic             tick_in,
  output logic             tick_en,
  output logic [WIDTH-1:0] remaining,
  output logic             busy,
  output logic             done,
  output logic             expired
);

  state_t state_q, state_d;
  logic   load_en;
  logic   dec_en;
  logic   clr_en;
  logic   expire;

  // Next-state decode. Priority is cancel > start > tick_in > pause; the
  // state checks below only run when neither cancel nor start is present.
  // NOTE: every signal gets a default before any branch so this block can
  // never infer a latch on a path that forgets to assign it.
  always_comb begin
    state_d = state_q;
    load_en = 1'b0;
    dec_en  = 1'b0;
    clr_en  = 1'b0;
    expire  = 1'b0;

    if (cancel) begin
      state_d = IDLE;
      clr_en  = 1'b1;
    end else if (start) begin
      load_en = 1'b1;
      if (load_value == '0) begin
        state_d = DONE;
        expire  = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else begin
      unique case (state_q)
        RUN: begin
          // A tick arriving with pause is counted first; if it expires the
          // interval we land in DONE rather than PAUSED.
          if (tick_in) begin
            if (remaining <= WIDTH'(1)) begin
              state_d = DONE;
              clr_en  = 1'b1;
              expire  = 1'b1;
            end else begin
              dec_en = 1'b1;
              if (pause) state_d = PAUSED;
            end
          end else if (pause) begin
            state_d = PAUSED;
          end
        end
        PAUSED: if (!pause) state_d = RUN;
        default: ;  // IDLE and DONE hold; tick_in is ignored there
      endcase
    end
  end

  // State and flag registers. Flags are decoded from the next state so they
  // line up with the state register rather than lagging it by a cycle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous (sampled on clk) to match the rest of the
    // datapath; rst is not in the sensitivity list on purpose.
    if (!rst) begin
      state_q <= IDLE;
      tick_en <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      expired <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_en <= (state_d == RUN);
      busy    <= (state_d == RUN) || (state_d == PAUSED);
      // Back-to-back zero-length starts would otherwise pulse every cycle.
      done    <= expire && !done;
      expired <= (state_d == DONE);
    end
  end

  // Remaining-ms counter. dec_en is only raised when remaining > 1, so the
  // counter can never wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      remaining <= '0;
    end else if (clr_en) begin
      remaining <= '0;
    end else if (load_en) begin
      remaining <= load_value;
    end else if (dec_en) begin
      remaining <= remaining - WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_ms_countdown_timer.sv
// ----------------------------------------------------------------------------
// tb_ms_countdown_timer
// Self-checking bench for ms_countdown_timer: a table of single-cycle
// vectors followed by hand-written multi-cycle sequences (reset, countdown,
// pause, restart, prescaler-driven interval).
// ----------------------------------------------------------------------------
module tb_ms_countdown_timer;

  localparam int W      = 16;
  localparam int PERIOD = 50;   // scaled-down prescaler period for the bench

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] load_value;
  logic         pause;
  logic         cancel;
  logic         tick_drv;
  logic         tick_in;
  logic         tick_en;
  logic [W-1:0] remaining;
  logic         busy;
  logic         done;
  logic         expired;

  int checks   = 0;
  int failures = 0;
  int done_seen = 0;

  // Behavioural prescaler: clears while disabled, pulses every PERIOD cycles.
  logic use_presc = 1'b0;
  logic presc_tick;
  int   pcnt;

  always #5 clk = ~clk;

  assign tick_in = use_presc ? presc_tick : tick_drv;

  always @(posedge clk) begin
    if (!tick_en) begin
      pcnt       <= 0;
      presc_tick <= 1'b0;
    end else if (pcnt == PERIOD - 1) begin
      pcnt       <= 0;
      presc_tick <= 1'b1;
    end else begin
      pcnt       <= pcnt + 1;
      presc_tick <= 1'b0;
    end
  end

  ms_countdown_timer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .load_value (load_value),
    .pause      (pause),
    .cancel     (cancel),
    .tick_in    (tick_in),
    .tick_en    (tick_en),
    .remaining  (remaining),
    .busy       (busy),
    .done       (done),
    .expired    (expired)
  );

  typedef struct {
    logic         s;
    logic [W-1:0] lv;
    logic         p;
    logic         c;
    logic         t;
    logic [W-1:0] rem;
    logic         ten;
    logic         bsy;
    logic         dn;
    logic         exp;
  } vec_t;

  vec_t vecs[23];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Advance one clock edge and settle; outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
    if (done === 1'b1) done_seen++;
  endtask

  task automatic clear_pulses();
    start    = 1'b0;
    cancel   = 1'b0;
    tick_drv = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    step();
    clear_pulses();
  endtask

  // Idle for n-1 cycles then deliver one tick.
  task automatic tick_after(input int n);
    repeat (n - 1) step();
    tick_drv = 1'b1;
    step();
    tick_drv = 1'b0;
  endtask

  function automatic logic [31:0] outs();
    return {12'h0, remaining, tick_en, busy, done, expired};
  endfunction

  initial begin
    int bad;
    int n;
    int d0;

    //          s     lv        p     c     t     rem       ten   bsy   dn    exp
    vecs[0]  = '{1'b1, 16'd3,     1'b0, 1'b0, 1'b0, 16'd3,     1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 16'd0,     1'b0, 1'b0, 1'b0, 16'd3,     1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 16'd0,     1'b0, 1'b0, 1'b1, 16'd2,     1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 16'd0,     1'b1, 1'b0, 1'b1, 16'd1,     1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 16'd0,     1'b1, 1'b0, 1'b1, 16'd1,     1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 16'd0,     1'b0, 1'b0, 1'b0, 16'd1,     1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 16'd0,     1'b1, 1'b0, 1'b1, 16'd0,     1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 16'd0,     1'b0, 1'b0, 1'b0, 16'd0,     1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 16'd0,     1'b0, 1'b0, 1'b1, 16'd0,     1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 16'd0,     1'b0, 1'b0, 1'b0, 16'd0,     1'b0, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 16'd0,     1'b0, 1'b0, 1'b0, 16'd0,     1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 16'd0,     1'b0, 1'b1, 1'b0, 16'd0,     1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 16'd0,     1'b0, 1'b0, 1'b1, 16'd0,     1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 16'd5,     1'b0, 1'b1, 1'b0, 16'd0,     1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 16'd1,     1'b0, 1'b0, 1'b0, 16'd1,     1'b1, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 16'd9,     1'b1, 1'b0, 1'b0, 16'd9,     1'b1, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 16'd0,     1'b1, 1'b0, 1'b0, 16'd9,     1'b0, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 16'd4,     1'b1, 1'b0, 1'b0, 16'd4,     1'b1, 1'b1, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 16'd0,     1'b0, 1'b0, 1'b1, 16'd3,     1'b1, 1'b1, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 16'd0,     1'b0, 1'b1, 1'b1, 16'd0,     1'b0, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{1'b1, 16'hFFFF,  1'b0, 1'b0, 1'b0, 16'hFFFF,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 16'd0,     1'b0, 1'b0, 1'b1, 16'hFFFE,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 16'd0,     1'b0, 1'b1, 1'b0, 16'd0,     1'b0, 1'b0, 1'b0, 1'b0};

    // Reset held for 3 cycles with start asserted.
    rst        = 1'b0;
    start      = 1'b1;
    load_value = 16'd5;
    pause      = 1'b0;
    cancel     = 1'b0;
    tick_drv   = 1'b0;
    repeat (3) step();
    check("reset_outputs", outs(), 32'h0);
    rst   = 1'b1;
    start = 1'b0;
    step();
    check("post_reset_idle", outs(), 32'h0);

    // Single-cycle vector table.
    for (int i = 0; i < 23; i++) begin
      start      = vecs[i].s;
      load_value = vecs[i].lv;
      pause      = vecs[i].p;
      cancel     = vecs[i].c;
      tick_drv   = vecs[i].t;
      step();
      check($sformatf("vec%0d", i), outs(),
            {12'h0, vecs[i].rem, vecs[i].ten, vecs[i].bsy, vecs[i].dn, vecs[i].exp});
    end
    clear_pulses();
    pause = 1'b0;

    // Basic countdown: load 3, tick every 10 cycles.
    d0         = done_seen;
    start      = 1'b1;
    load_value = 16'd3;
    step();
    start = 1'b0;
    check("basic_tick_en_after_start", {31'h0, tick_en}, 32'd1);
    for (int t = 0; t < 3; t++) begin
      tick_after(10);
      check($sformatf("basic_rem_tick%0d", t), {16'h0, remaining}, 32'(2 - t));
      check($sformatf("basic_done_tick%0d", t), {31'h0, done}, {31'h0, (t == 2)});
    end
    step();
    check("basic_after_expiry", {28'h0, tick_en, busy, done, expired}, 32'h1);
    check("basic_single_done", done_seen - d0, 32'd1);
    do_cancel();
    check("cancel_from_done", outs(), 32'h0);

    // Pause: load 5, two ticks, then 30 cycles paused with 3 ticks.
    start      = 1'b1;
    load_value = 16'd5;
    step();
    start = 1'b0;
    tick_after(10);
    tick_after(10);
    check("pause_rem_before", {16'h0, remaining}, 32'd3);
    pause = 1'b1;
    bad   = 0;
    for (int c = 0; c < 30; c++) begin
      tick_drv = (c % 10 == 5);
      step();
      if (remaining !== 16'd3 || tick_en !== 1'b0 || busy !== 1'b1) bad++;
    end
    tick_drv = 1'b0;
    check("pause_hold_bad_cycles", bad, 32'd0);
    pause = 1'b0;
    step();
    check("resume_run", {16'h0, remaining[14:0], tick_en}, {16'h0, 15'd3, 1'b1});
    pause    = 1'b1;
    tick_drv = 1'b1;
    step();
    tick_drv = 1'b0;
    check("pause_with_tick_counted", {16'h0, remaining[14:0], tick_en}, {16'h0, 15'd2, 1'b0});
    pause = 1'b0;
    do_cancel();

    // Restart mid-run: load 10, reload 7 at remaining=4.
    d0         = done_seen;
    start      = 1'b1;
    load_value = 16'd10;
    step();
    start = 1'b0;
    repeat (6) tick_after(2);
    check("restart_rem_at_4", {16'h0, remaining}, 32'd4);
    start      = 1'b1;
    load_value = 16'd7;
    step();
    start = 1'b0;
    check("restart_outputs", outs(), {12'h0, 16'd7, 4'b1100});
    check("restart_no_done", done_seen - d0, 32'd0);
    do_cancel();

    // Prescaler-driven interval: load 2 -> done about 2*PERIOD cycles later.
    use_presc  = 1'b1;
    start      = 1'b1;
    load_value = 16'd2;
    step();
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 500) begin
      step();
      n++;
    end
    check("presc_done_window",
          {31'h0, (n >= 2 * PERIOD - 2) && (n <= 2 * PERIOD + 2)}, 32'd1);
    if (n >= 500) $display("FAIL presc_timeout actual=%0d required=%0d", n, 2 * PERIOD);
    use_presc = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
